fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Pair fields are sized for the widest supported PC/instruction (64 bits).
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PAIR_BYTES  = 2 * INSTR_BYTES;
  localparam int unsigned MAX_XLEN    = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [MAX_XLEN-1:0] instr1;
    logic [MAX_XLEN-1:0] instr2;
    logic                slot1_only;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch-pair queue with flush; a write is accepted while full
// if a read happens in the same cycle.
module fetch_fifo import fetch_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  fetch_pair_t              wr_data,
  input  logic                     rd_en,
  output fetch_pair_t              rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  fetch_pair_t mem_q [DEPTH];
  logic        do_wr, do_rd;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: pair fetch, redirect handling, dual-issue queue.
// Define FETCH_STATS_EN to build the ROB_full stall counter (stall_cycles).
module fetch_ctrl import fetch_pkg::*; #(
  parameter int unsigned           PC_WIDTH    = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           FQ_DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata1,
  input  logic [INSTR_WIDTH-1:0] imem_rdata2,
  input  logic                   ROB_full,
  input  logic                   flush_en,
  input  logic                   branch_en,
  input  logic                   jump_en,
  input  logic [PC_WIDTH-1:0]    flush_PC,
  input  logic [PC_WIDTH-1:0]    branch_PC,
  input  logic [PC_WIDTH-1:0]    jump_PC,
  output logic [PC_WIDTH-1:0]    PC_in1,
  output logic [PC_WIDTH-1:0]    PC_in2,
  output logic [INSTR_WIDTH-1:0] instruction1,
  output logic [INSTR_WIDTH-1:0] instruction2,
  output logic                   ins1_valid,
  output logic                   ins2_valid,
  output logic [31:0]            stall_cycles
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  inflight_q;
  logic [PC_WIDTH-1:0]   req_pc_q;
  logic                  req_slot1_q;
  logic                  redirect;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic [CW:0]           occupancy;

  logic                  fq_wr, fq_rd, fq_empty, fq_full;
  logic [CW-1:0]         fq_count;
  fetch_pair_t           fq_wdata, fq_head;

  always_comb begin
    redirect    = flush_en || branch_en || jump_en;
    redirect_pc = jump_PC;
    if (branch_en) redirect_pc = branch_PC;
    if (flush_en)  redirect_pc = flush_PC;
  end

  // Requests in flight count against queue space so no response is ever dropped.
  assign occupancy = {1'b0, fq_count} + {{CW{1'b0}}, inflight_q};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_en    = 1'b0;
    imem_addr  = '0;
    fq_wr      = inflight_q;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH: begin
        if (occupancy < (CW+1)'(FQ_DEPTH)) begin
          imem_en    = 1'b1;
          imem_addr  = {fetch_pc_q[PC_WIDTH-1:3], 3'b000};
          fetch_pc_d = fetch_pc_q + (fetch_pc_q[2] ? PC_WIDTH'(INSTR_BYTES)
                                                   : PC_WIDTH'(PAIR_BYTES));
        end
      end
      REDIRECT: state_d = FETCH;
      default:  state_d = IDLE;
    endcase
    if (redirect) begin
      state_d    = REDIRECT;
      fetch_pc_d = redirect_pc;
      imem_en    = 1'b0;
      imem_addr  = '0;
      fq_wr      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      inflight_q  <= 1'b0;
      req_pc_q    <= '0;
      req_slot1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= imem_en;
      if (imem_en) begin
        req_pc_q    <= fetch_pc_q;
        req_slot1_q <= fetch_pc_q[2];
      end
    end
  end

  // A pair entered at an odd word issues only its upper word, in slot 1.
  always_comb begin
    fq_wdata            = '0;
    fq_wdata.pc         = MAX_XLEN'(req_pc_q);
    fq_wdata.instr1     = MAX_XLEN'(req_slot1_q ? imem_rdata2 : imem_rdata1);
    fq_wdata.instr2     = MAX_XLEN'(imem_rdata2);
    fq_wdata.slot1_only = req_slot1_q;
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .wr_en   (fq_wr),
    .wr_data (fq_wdata),
    .rd_en   (fq_rd),
    .rd_data (fq_head),
    .empty   (fq_empty),
    .full    (fq_full),
    .count   (fq_count)
  );

  assign ins1_valid   = !fq_empty && !ROB_full && (state_q != REDIRECT) && !redirect;
  assign ins2_valid   = ins1_valid && !fq_head.slot1_only;
  assign fq_rd        = ins1_valid;
  assign PC_in1       = ins1_valid ? fq_head.pc[PC_WIDTH-1:0] : '0;
  assign PC_in2       = ins1_valid ? fq_head.pc[PC_WIDTH-1:0] + PC_WIDTH'(INSTR_BYTES) : '0;
  assign instruction1 = ins1_valid ? fq_head.instr1[INSTR_WIDTH-1:0] : '0;
  assign instruction2 = ins2_valid ? fq_head.instr2[INSTR_WIDTH-1:0] : '0;

  logic unused_hi;
  assign unused_hi = ^{fq_head.pc >> PC_WIDTH, fq_head.instr1 >> INSTR_WIDTH,
                       fq_head.instr2 >> INSTR_WIDTH, fq_full};

`ifdef FETCH_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (ROB_full && !fq_empty && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: startup, jump, redirect priority, ROB stall, async reset.
module tb_fetch_ctrl;

  localparam int unsigned PCW   = 32;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          imem_en;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata1, imem_rdata2;
  logic          ROB_full, flush_en, branch_en, jump_en;
  logic [31:0]   flush_PC, branch_PC, jump_PC;
  logic [31:0]   PC_in1, PC_in2, instruction1, instruction2;
  logic          ins1_valid, ins2_valid;
  logic [31:0]   stall_cycles;

  int total;
  int bad;

  fetch_ctrl #(
    .PC_WIDTH    (PCW),
    .INSTR_WIDTH (IW),
    .FQ_DEPTH    (DEPTH),
    .RESET_PC    (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata1  (imem_rdata1),
    .imem_rdata2  (imem_rdata2),
    .ROB_full     (ROB_full),
    .flush_en     (flush_en),
    .branch_en    (branch_en),
    .jump_en      (jump_en),
    .flush_PC     (flush_PC),
    .branch_PC    (branch_PC),
    .jump_PC      (jump_PC),
    .PC_in1       (PC_in1),
    .PC_in2       (PC_in2),
    .instruction1 (instruction1),
    .instruction2 (instruction2),
    .ins1_valid   (ins1_valid),
    .ins2_valid   (ins2_valid),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory returns the pair one cycle after the request; junk otherwise.
  always @(posedge clk) begin
    if (imem_en) begin
      imem_rdata1 <= word_at(imem_addr);
      imem_rdata2 <= word_at(imem_addr + 32'd4);
    end else begin
      imem_rdata1 <= 32'hDEAD_BEEF;
      imem_rdata2 <= 32'hDEAD_BEEF;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle after release).
  task automatic do_reset();
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    #1;
    total++;
    if ({imem_en, ins1_valid, ins2_valid} !== 3'b000 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got en/v1/v2=%b%b%b addr=%h want 000 addr=0",
               imem_en, ins1_valid, ins2_valid, imem_addr);
    end
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_stall: got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_startup();
    logic [31:0] exp_addr;
    do_reset();
    #1;
    total++;
    if (imem_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_fetch: got imem_en=%b want 0", imem_en);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      #1;
      exp_addr = 32'(8 * (c - 1));
      total++;
      if (imem_en !== 1'b1 || imem_addr !== exp_addr) begin
        bad++;
        $display("FAIL startup_addr_c%0d: got en=%b addr=%h want en=1 addr=%h",
                 c, imem_en, imem_addr, exp_addr);
      end
      if (c < 3) begin
        total++;
        if (ins1_valid !== 1'b0) begin
          bad++;
          $display("FAIL startup_early_valid_c%0d: got %b want 0", c, ins1_valid);
        end
      end
    end
    total++;
    if (ins1_valid !== 1'b1 || ins2_valid !== 1'b1 || PC_in1 !== 32'h0 || PC_in2 !== 32'h4 ||
        instruction1 !== word_at(32'h0) || instruction2 !== word_at(32'h4)) begin
      bad++;
      $display("FAIL first_issue: got v=%b%b pc=%h/%h ins=%h/%h want v=11 pc=0/4 ins=%h/%h",
               ins1_valid, ins2_valid, PC_in1, PC_in2, instruction1, instruction2,
               word_at(32'h0), word_at(32'h4));
    end
    step();
    #1;
    total++;
    if (ins1_valid !== 1'b1 || PC_in1 !== 32'h8) begin
      bad++;
      $display("FAIL second_issue: got v=%b pc=%h want v=1 pc=8", ins1_valid, PC_in1);
    end
  endtask

  task automatic test_jump();
    step();
    jump_en = 1'b1;
    jump_PC = 32'h104;
    #1;
    total++;
    if (ins1_valid !== 1'b0 || imem_en !== 1'b0) begin
      bad++;
      $display("FAIL jump_cycle_quiet: got v1=%b en=%b want 0 0", ins1_valid, imem_en);
    end
    step();
    jump_en = 1'b0;
    #1;
    total++;
    if (ins1_valid !== 1'b0 || imem_en !== 1'b0) begin
      bad++;
      $display("FAIL jump_next_quiet: got v1=%b en=%b want 0 0", ins1_valid, imem_en);
    end
    step();
    #1;
    total++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL jump_addr: got en=%b addr=%h want en=1 addr=100", imem_en, imem_addr);
    end
    step();
    #1;
    total++;
    if (imem_addr !== 32'h108 || ins1_valid !== 1'b0) begin
      bad++;
      $display("FAIL jump_addr2: got addr=%h v1=%b want addr=108 v1=0", imem_addr, ins1_valid);
    end
    step();
    #1;
    total++;
    if (ins1_valid !== 1'b1 || ins2_valid !== 1'b0 || PC_in1 !== 32'h104 ||
        instruction1 !== word_at(32'h104)) begin
      bad++;
      $display("FAIL jump_single: got v=%b%b pc=%h ins=%h want v=10 pc=104 ins=%h",
               ins1_valid, ins2_valid, PC_in1, instruction1, word_at(32'h104));
    end
    step();
    #1;
    total++;
    if (ins1_valid !== 1'b1 || ins2_valid !== 1'b1 || PC_in1 !== 32'h108 ||
        PC_in2 !== 32'h10c) begin
      bad++;
      $display("FAIL jump_pair: got v=%b%b pc=%h/%h want v=11 pc=108/10c",
               ins1_valid, ins2_valid, PC_in1, PC_in2);
    end
  endtask

  task automatic test_priority();
    step();
    flush_en  = 1'b1;  flush_PC  = 32'h200;
    branch_en = 1'b1;  branch_PC = 32'h300;
    jump_en   = 1'b1;  jump_PC   = 32'h400;
    #1;
    total++;
    if (ins1_valid !== 1'b0) begin
      bad++;
      $display("FAIL prio_cycle_quiet: got v1=%b want 0", ins1_valid);
    end
    step();
    flush_en = 1'b0;
    branch_en = 1'b0;
    jump_en = 1'b0;
    step();
    #1;
    total++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h200) begin
      bad++;
      $display("FAIL prio_addr: got en=%b addr=%h want en=1 addr=200", imem_en, imem_addr);
    end
    step();
    #1;
    total++;
    if (ins1_valid !== 1'b0) begin
      bad++;
      $display("FAIL prio_queue_empty: got v1=%b pc=%h want v1=0", ins1_valid, PC_in1);
    end
    step();
    #1;
    total++;
    if (ins1_valid !== 1'b1 || ins2_valid !== 1'b1 || PC_in1 !== 32'h200) begin
      bad++;
      $display("FAIL prio_first: got v=%b%b pc=%h want v=11 pc=200",
               ins1_valid, ins2_valid, PC_in1);
    end
  endtask

  task automatic test_rob_full();
    int          nfetch;
    int          got;
    logic [31:0] exp_pc;
    logic [31:0] exp_stall;
    nfetch = 0;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 3) ROB_full = 1'b1;
      #1;
      if (imem_en) nfetch++;
      if (c >= 3) begin
        total++;
        if (ins1_valid !== 1'b0 || ins2_valid !== 1'b0) begin
          bad++;
          $display("FAIL stall_valid_c%0d: got v=%b%b want 00", c, ins1_valid, ins2_valid);
        end
      end
    end
    step();
    ROB_full = 1'b0;
    #1;
    total++;
    if (nfetch != DEPTH) begin
      bad++;
      $display("FAIL stall_fetch_count: got %0d want %0d", nfetch, DEPTH);
    end
`ifdef FETCH_STATS_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++;
      $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, exp_stall);
    end
    exp_pc = 32'h0;
    got = 0;
    for (int b = 0; b < 40 && got < 8; b++) begin
      if (ins1_valid === 1'b1) begin
        total++;
        if (PC_in1 !== exp_pc || instruction1 !== word_at(exp_pc) ||
            instruction2 !== word_at(exp_pc + 32'd4)) begin
          bad++;
          $display("FAIL drain_order_%0d: got pc=%h ins=%h/%h want pc=%h ins=%h/%h", got,
                   PC_in1, instruction1, instruction2, exp_pc, word_at(exp_pc),
                   word_at(exp_pc + 32'd4));
        end
        exp_pc = exp_pc + 32'd8;
        got++;
      end
      step();
      #1;
    end
    total++;
    if (got != 8) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pairs want 8", got);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      step();
      ROB_full = (c == 3 || c == 4);
    end
    #1;
    total++;
    if (ins1_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_valid: got %b want 1", ins1_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({imem_en, ins1_valid, ins2_valid} !== 3'b000 || imem_addr !== 32'h0 ||
        stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: got en/v=%b%b%b addr=%h stall=%0d want 000 0 0",
               imem_en, ins1_valid, ins2_valid, imem_addr, stall_cycles);
    end
    step();
    step();
    rst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      #1;
      if (c == 1) begin
        total++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin
          bad++;
          $display("FAIL restart_addr: got en=%b addr=%h want en=1 addr=0", imem_en, imem_addr);
        end
      end
      if (c < 3) begin
        total++;
        if (ins1_valid !== 1'b0) begin
          bad++;
          $display("FAIL stale_emitted_c%0d: got v1=%b pc=%h want v1=0", c, ins1_valid, PC_in1);
        end
      end
    end
    total++;
    if (ins1_valid !== 1'b1 || PC_in1 !== 32'h0 || instruction1 !== word_at(32'h0)) begin
      bad++;
      $display("FAIL restart_first: got v1=%b pc=%h ins=%h want v1=1 pc=0 ins=%h",
               ins1_valid, PC_in1, instruction1, word_at(32'h0));
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    clk = 1'b0;
    rst = 1'b0;
    ROB_full = 1'b0;
    flush_en = 1'b0;
    branch_en = 1'b0;
    jump_en = 1'b0;
    flush_PC = '0;
    branch_PC = '0;
    jump_PC = '0;
    test_reset();
    test_startup();
    test_jump();
    test_priority();
    test_rob_full();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
